serial_frame_tx: RTL and testbench

//  Upstream serializer for the 4-bit serial-in shift register stage.
//  - Accepts parallel words over a valid/ready handshake.
//  - Emits each word as a framed bit stream on sout, wired to the shift register's serial input E:

---
 rtl/serial_frame_pkg.sv | 13 +
 rtl/serial_frame_tx_bit_timer.sv | 15 +
 rtl/serial_frame_tx.sv | 92 +++++++++
 tb/tb_serial_frame_tx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: state encodings and line levels shared by serial_frame_tx
package serial_frame_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: per-bit cycle counter; bit_last_o marks the final cycle of the current bit
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic load_i,
  output logic bit_last_o
);
  logic [15:0] bit_cnt_q, bit_cnt_d;
  assign bit_last_o = bit_cnt_q == 16'(BIT_CYCLES - 1);
  assign bit_cnt_d = (idle_i || load_i || bit_last_o) ? '0 : bit_cnt_q + 16'd1;
  always_ff @(posedge clk) bit_cnt_q <= rst ? '0 : bit_cnt_d;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed LSB-first serializer (start, data, [parity], stop) with valid/ready input.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             bit_strobe
);
  localparam int IW = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sout_q, busy_q, strobe_q, sout_d;
  logic             bit_last, accept, last_idx;
  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .idle_i    (state_q == ST_IDLE),
    .load_i    (accept),
    .bit_last_o(bit_last)
  );
  assign din_ready = (state_q == ST_IDLE) || (state_q == ST_STOP && bit_last);
  assign accept    = din_valid && din_ready;
  assign last_idx  = idx_q == IW'(WIDTH - 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : accept ? ^din : par_q;
  assign sout_d = state_d == ST_START ? START_LVL : state_d == ST_DATA ? word_d[0] :
                  state_d == ST_PARITY ? par_q : state_d == ST_STOP ? STOP_LVL : LINE_IDLE;
`else
  assign sout_d = state_d == ST_START ? START_LVL : state_d == ST_DATA ? word_d[0] :
                  state_d == ST_STOP ? STOP_LVL : LINE_IDLE;
`endif
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = ST_START;
      word_d  = din;
      idx_d   = '0;
    end else if (bit_last) begin
      case (state_q)
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          word_d = word_q >> 1;
          idx_d  = idx_q + IW'(1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
          if (last_idx) state_d = ST_PARITY;
`else
          if (last_idx) state_d = ST_STOP;
`endif
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        ST_STOP: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  // Outputs are registered from next-state values so they line up with state_q each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      sout_q   <= LINE_IDLE;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      sout_q   <= sout_d;
      busy_q   <= state_d != ST_IDLE;
      strobe_q <= state_d == ST_DATA && bit_last;
    end
  end
  assign sout       = sout_q;
  assign busy       = busy_q;
  assign bit_strobe = strobe_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed + random frames on three configurations against a per-cycle frame model
module tb_serial_frame_tx;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic       clk, rst;
  logic [7:0] din_a [3];
  logic       val_a [3];
  logic       ready_a [3];
  logic       sout_a [3];
  logic       busy_a [3];
  logic       stb_a [3];
  logic [3:0] sr;
  int         checks = 0;
  int         errors = 0;

  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1)) u8 (
    .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(val_a[0]), .din_ready(ready_a[0]),
    .sout(sout_a[0]), .busy(busy_a[0]), .bit_strobe(stb_a[0]));
  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(val_a[1]), .din_ready(ready_a[1]),
    .sout(sout_a[1]), .busy(busy_a[1]), .bit_strobe(stb_a[1]));
  serial_frame_tx #(.WIDTH(4), .BIT_CYCLES(1)) u4 (
    .clk(clk), .rst(rst), .din(din_a[2][3:0]), .din_valid(val_a[2]), .din_ready(ready_a[2]),
    .sout(sout_a[2]), .busy(busy_a[2]), .bit_strobe(stb_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  // downstream 4-bit stage fed from the WIDTH=4 instance: E -> D -> C -> B -> A
  always @(posedge clk) sr <= {sr[2:0], sout_a[2]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one frame cycle by cycle; the first edge inside is the accepting edge.
  task automatic watch(input int i, input logic [31:0] w, input bit chain, input logic [31:0] w2);
    int wd = (i == 2) ? 4 : 8;
    int bc = (i == 1) ? 3 : 1;
    int len = (wd + 2 + PAR) * bc;
    int pos, nstb;
    logic [31:0] mask = (32'd1 << wd) - 32'd1;
    logic es;
    nstb = 0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (chain) din_a[i] = w2[7:0];
        else val_a[i] = 1'b0;
      end
      pos = k / bc;
      es = pos == 0 ? 1'b0 : pos <= wd ? w[pos-1] : (PAR == 1 && pos == wd + 1) ? ^(w & mask) : 1'b1;
      check("sout", sout_a[i], es);
      check("busy", busy_a[i], 1);
      check("bit_strobe", stb_a[i], pos >= 1 && pos <= wd && k % bc == 0);
      check("din_ready", ready_a[i], k == len - 1);
      nstb += int'(stb_a[i]);
      if (i == 2 && k == wd + 1) check("shift_abcd", sr, {w[0], w[1], w[2], w[3]});
    end
    check("strobe_count", nstb, wd);
  endtask

  task automatic idle(input int i);
    @(posedge clk); #1;
    check("idle_sout", sout_a[i], 1);
    check("idle_busy", busy_a[i], 0);
    check("idle_ready", ready_a[i], 1);
  endtask

  task automatic send(input int i, input logic [31:0] w, input bit chain, input logic [31:0] w2);
    din_a[i] = w[7:0];
    val_a[i] = 1'b1;
    check("ready_pre", ready_a[i], 1);
    watch(i, w, chain, w2);
    if (chain) watch(i, w2, 1'b0, 0);
    idle(i);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val_a[i] = 1'b1;
      din_a[i] = 8'($urandom);
    end
    repeat (2) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        check("rst_sout", sout_a[i], 1);
        check("rst_busy", busy_a[i], 0);
        check("rst_strobe", stb_a[i], 0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      val_a[i] = 1'b0;
      check("rst_ready", ready_a[i], 1);
    end
    send(0, 32'hA5, 1'b0, 0);
    send(0, 32'h0F, 1'b1, 32'hF0);
    send(1, 32'h01, 1'b0, 0);
    send(0, 32'h07, 1'b0, 0);
    send(0, 32'h03, 1'b0, 0);
    send(2, 32'hB, 1'b0, 0);
    din_a[0] = 8'hFF;
    val_a[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      val_a[0] = 1'b0;
      check("abort_sout_pre", sout_a[0], k != 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_sout", sout_a[0], 1);
    check("abort_busy", busy_a[0], 0);
    check("abort_strobe", stb_a[0], 0);
    check("abort_ready", ready_a[0], 1);
    send(0, 32'h3C, 1'b0, 0);
    repeat (8) send(0, $urandom & 32'hFF, 1'($urandom), $urandom & 32'hFF);
    repeat (3) send(1, $urandom & 32'hFF, 1'($urandom), $urandom & 32'hFF);
    repeat (6) send(2, $urandom & 32'hF, 1'($urandom), $urandom & 32'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
